// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master RAM arbiter: command encoding and FSM states.
// Command values must stay identical to the CPU's mem_cmd encoding.
package mem_arb_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WAIT   = 2'b10,
        ACK    = 2'b11
    } state_e;

    // Encoding 11 is a no-op; the top address bit routes to the I/O decoder instead.
    function automatic logic is_ram_req(input logic [1:0] cmd, input logic space_bit);
        return ((cmd == MREAD) || (cmd == MWRITE)) && !space_bit;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational 2-way round-robin picker for the RAM arbiter.
// MEM_ARB_FIXED_PRIO_EN makes master 0 win every tie and ignores last_grant.
module mem_arb_rr (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_valid_o,
    output logic       grant_id_o
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
`endif

    always_comb begin
        grant_valid_o = |req_i;
        grant_id_o    = 1'b0;
        if (req_i == 2'b10) begin
            grant_id_o = 1'b1;
        end else if (req_i == 2'b11) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            grant_id_o = 1'b0;
`else
            grant_id_o = ~last_grant_i;
`endif
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter/sequencer for the shared 256x16 single-port RAM.
// Tie-break policy is selected by MEM_ARB_FIXED_PRIO_EN (see mem_arb_rr).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        m0_cmd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    input  logic [1:0]        m1_cmd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-2:0] ram_addr,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [1:0]        dbg_state_o
);

    // Handshake: a master holds cmd/addr/wdata until its ack, which is a single-cycle
    // pulse; rdata is valid during that cycle and may change again only on a later read.
    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                win_id_q, win_id_d;
    logic [ADDR_W-2:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [1:0] req;
    logic       grant_valid;
    logic       grant_id;

    assign req[0] = is_ram_req(m0_cmd, m0_addr[ADDR_W-1]);
    assign req[1] = is_ram_req(m1_cmd, m1_addr[ADDR_W-1]);

    mem_arb_rr u_rr (
        .req_i         (req),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        win_id_d     = win_id_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    win_id_d     = grant_id;
                    last_grant_d = grant_id;
                    addr_d       = grant_id ? m1_addr[ADDR_W-2:0] : m0_addr[ADDR_W-2:0];
                    wdata_d      = grant_id ? m1_wdata : m0_wdata;
                    write_d      = grant_id ? (m1_cmd == MWRITE) : (m0_cmd == MWRITE);
                    state_d      = ACCESS;
                end
            end
            ACCESS:  state_d = write_q ? ACK : WAIT;
            WAIT: begin
                rdata_d = ram_dout;
                state_d = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            win_id_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            win_id_q     <= win_id_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            rdata_q      <= rdata_d;
        end
    end

    // Gating with reset keeps a write from landing in the cycle that aborts it.
    assign ram_write   = (state_q == ACCESS) & write_q & reset;
    assign ram_addr    = addr_q;
    assign ram_din     = wdata_q;
    assign rdata       = rdata_q;
    assign m0_ack      = (state_q == ACK) & ~win_id_q;
    assign m1_ack      = (state_q == ACK) & win_id_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random two-master traffic,
// checked cycle by cycle against a transaction-level timing and memory model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  m0_cmd = MNONE, m1_cmd = MNONE;
    logic [8:0]  m0_addr = '0, m1_addr = '0;
    logic [15:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_ack, m1_ack;
    logic [15:0] rdata;
    logic [7:0]  ram_addr;
    logic        ram_write;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic [1:0]  dbg_state_o;

    logic [15:0] ram [256];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          model_on = 0;

    // Reference model: one access in flight, known grant and ack cycles
    bit          ev_valid = 0;
    bit          ev_id, ev_write;
    logic [7:0]  ev_addr;
    logic [15:0] ev_data;
    int          ev_g, ev_ack;
    int          exp_free = 0;
    bit          exp_last = 1;
    logic [15:0] exp_rdata = '0;
    logic [15:0] exp_mem [256];

    mem_arbiter #(.ADDR_W(9), .DATA_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .m0_cmd      (m0_cmd),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_ack      (m0_ack),
        .m1_cmd      (m1_cmd),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_ack      (m1_ack),
        .rdata       (rdata),
        .ram_addr    (ram_addr),
        .ram_write   (ram_write),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout),
        .dbg_state_o (dbg_state_o)
    );

    // Clock, cycle counter and the registered-output RAM
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        if (ram_write) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit id, input logic [1:0] cmd, input logic [8:0] addr,
                         input logic [15:0] wd);
        if (id) begin
            m1_cmd = cmd; m1_addr = addr; m1_wdata = wd;
        end else begin
            m0_cmd = cmd; m0_addr = addr; m0_wdata = wd;
        end
    endtask

    // Issue a request and hold it until acked (bounded), then release it.
    task automatic do_req(input bit id, input logic [1:0] cmd, input logic [8:0] addr,
                          input logic [15:0] wd);
        bit got = 0;
        drive(id, cmd, addr, wd);
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            if ((id ? m1_ack : m0_ack) === 1'b1) begin
                got = 1;
                break;
            end
        end
        chk(id ? "m1_ack_wait" : "m0_ack_wait", 32'(got), 32'd1);
        tick(1);
        drive(id, MNONE, addr, wd);
    endtask

    // Drive a request the arbiter must ignore for n cycles.
    task automatic hold(input bit id, input logic [1:0] cmd, input logic [8:0] addr, input int n);
        drive(id, cmd, addr, 16'($urandom));
        tick(n);
        drive(id, MNONE, addr, 16'h0);
    endtask

    task automatic rand_master(input bit id, input int ops);
        for (int k = 0; k < ops; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 7)
                do_req(id, ($urandom_range(0, 1) != 0) ? MWRITE : MREAD,
                       {1'b0, 8'($urandom_range(0, 31))}, 16'($urandom));
            else if (r == 7)
                hold(id, MREAD, {1'b1, 8'($urandom)}, $urandom_range(1, 3));
            else if (r == 8)
                hold(id, 2'b11, {1'b0, 8'($urandom)}, $urandom_range(1, 3));
            else
                tick($urandom_range(0, 3));
        end
    endtask

    // Model process: checks every cycle at the falling edge, then arbitrates.
    initial begin
        bit v0, v1, w, exp_wr;
        for (int i = 0; i < 256; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            ram[i] <= v;
            exp_mem[i] = v;
        end
        forever begin
            @(negedge clk);
            if (model_on) begin
                exp_wr = ev_valid && ev_write && (cyc == ev_g + 1) && reset;
                chk("ram_write", 32'(ram_write), 32'(exp_wr));
                if (exp_wr) begin
                    chk("wr_addr", 32'(ram_addr), 32'(ev_addr));
                    chk("wr_din", 32'(ram_din), 32'(ev_data));
                    exp_mem[ev_addr] = ev_data;
                end
                if (ev_valid && !ev_write && (cyc == ev_g + 1))
                    chk("rd_addr", 32'(ram_addr), 32'(ev_addr));
                chk("m0_ack", 32'(m0_ack), 32'(ev_valid && cyc == ev_ack && !ev_id));
                chk("m1_ack", 32'(m1_ack), 32'(ev_valid && cyc == ev_ack && ev_id));
                if (ev_valid && cyc == ev_ack && !ev_write) exp_rdata = ev_data;
                chk("rdata", 32'(rdata), 32'(exp_rdata));
                chk("idle", 32'(dbg_state_o == IDLE), 32'(cyc >= exp_free));
            end
            if (!reset) begin
                ev_valid = 0; exp_free = cyc + 1; exp_last = 1; exp_rdata = '0;
            end else if (ev_valid && cyc == ev_ack) begin
                ev_valid = 0;
            end
            if (reset && !ev_valid && cyc >= exp_free) begin
                v0 = (m0_cmd == MREAD || m0_cmd == MWRITE) && !m0_addr[8];
                v1 = (m1_cmd == MREAD || m1_cmd == MWRITE) && !m1_addr[8];
                if (v0 || v1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                    w = v0 ? 1'b0 : 1'b1;
`else
                    w = (v0 && v1) ? ~exp_last : v1;
`endif
                    exp_last = w;
                    ev_valid = 1;
                    ev_id    = w;
                    ev_write = ((w ? m1_cmd : m0_cmd) == MWRITE);
                    ev_addr  = w ? m1_addr[7:0] : m0_addr[7:0];
                    ev_g     = cyc;
                    ev_ack   = cyc + (ev_write ? 2 : 3);
                    exp_free = ev_ack + 1;
                    ev_data  = ev_write ? (w ? m1_wdata : m0_wdata) : exp_mem[ev_addr];
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(3);
        reset = 1'b1;
        model_on = 1;
        @(negedge clk);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        chk("rst_ram_din", 32'(ram_din), 32'h0);
        chk("rst_acks", 32'({m0_ack, m1_ack}), 32'h0);
        tick(1);

        do_req(0, MWRITE, 9'h005, 16'hBEEF);
        do_req(1, MWRITE, 9'h006, 16'h1234);
        do_req(0, MREAD, 9'h005, 16'h0);
        chk("readback", 32'(rdata), 32'hBEEF);

        reset = 1'b0; tick(1); reset = 1'b1;
        fork
            do_req(0, MREAD, 9'h005, 16'h0);
            do_req(1, MREAD, 9'h006, 16'h0);
        join
        chk("pair1_last", 32'(rdata), 32'h1234);
        fork
            do_req(0, MREAD, 9'h005, 16'h0);
            do_req(1, MREAD, 9'h006, 16'h0);
        join

        hold(1, MREAD, 9'h140, 6);
        hold(0, 2'b11, 9'h010, 6);

        tick(2);
        drive(0, MWRITE, 9'h010, 16'hDEAD);
        tick(1);
        reset = 1'b0;
        drive(0, MNONE, 9'h010, 16'h0);
        tick(1);
        reset = 1'b1;
        fork
            do_req(0, MREAD, 9'h010, 16'h0);
            do_req(1, MREAD, 9'h006, 16'h0);
        join

        fork
            rand_master(0, 150);
            rand_master(1, 150);
        join
        tick(10);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter and sequencer for the shared 256×16 single-port RAM. The CPU is master 0; a second requester (loader or DMA) is master 1. Each master issues MREAD/MWRITE commands on the 9-bit memory address space. The block claims only RAM-space addresses (addr[8]==0), grants one access at a time in round-robin order, drives the RAM ports, and returns read data with a one-cycle acknowledge.

## Interface
Parameters:
- ADDR_W, 9: master address width; bit ADDR_W-1 selects RAM (0) vs non-RAM (1).
- DATA_W, 16: data width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- m0_cmd  in  2  master 0 command: MNONE=00, MREAD=01, MWRITE=10; 11 treated as MNONE
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_ack  out  1  one-cycle completion pulse for master 0
- m1_cmd, m1_addr, m1_wdata, m1_ack  same as master 0, for master 1
- rdata  out  DATA_W  registered read data; valid while the ack is high
- ram_addr  out  ADDR_W-1  RAM address
- ram_write  out  1  RAM write enable
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data, registered inside the RAM (valid one edge after the address)

## Operation
- A master request is valid when cmd ∈ {MREAD, MWRITE} and addr[8]==0. Requests with addr[8]==1 are never granted or acked; they belong to the I/O decoder.
- A master holds cmd, addr and wdata stable until it sees its ack. It may change them on the edge that ends the ack cycle.
- FSM states:
  - IDLE: arbitrate among valid requests. If any request is valid, latch the winner id, addr[7:0], wdata and the write flag, then go to ACCESS.
  - ACCESS: drive ram_addr from the latched address. Assert ram_write only for writes. Next state is ACK for a write, WAIT for a read.
  - WAIT: capture ram_dout into rdata, then go to ACK.
  - ACK: assert ack[winner] for exactly one cycle, then go to IDLE.
- Arbitration is round-robin. A last_grant register updates on each grant. With both masters valid, the master not last granted wins. A single valid master always wins.
- rdata holds its value until the next read capture. Writes do not alter rdata.
- ram_din always equals the latched wdata. ram_addr equals the latched address in every state.
- ram_write = (state==ACCESS) & write_flag & reset. A write is therefore never issued in a reset cycle.

## Timing
- Reset (reset==0 at an edge): state=IDLE, m0_ack=m1_ack=0, rdata=0, last_grant=1 (master 0 wins first), latched addr/wdata=0, ram_write=0. Reset mid-access aborts the access with no ack; the master must re-request.
- Write latency: request visible in cycle c0 gives ram_write high in c1 and ack in c2.
- Read latency: request in c0 gives ram_addr in c1, ram_dout captured at the end of c2, and ack with rdata valid in c3.
- Minimum spacing between grants is one IDLE cycle after ACK. Peak throughput is one write per 3 cycles or one read per 4 cycles.
- If both masters request in the same cycle, the loser's ack comes no earlier than the winner's ack + 3 (write) or + 4 (read) cycles.
- A request that appears during ACCESS, WAIT or ACK is evaluated only in the next IDLE.

## Configuration
- MEM_ARB_FIXED_PRIO_EN:
  - Defined: master 0 always wins ties and last_grant is not used. Master 1 can starve.
  - Undefined (default): round-robin as above.

## Structure
- Shared package mem_arb_pkg holds:
  - the MNONE/MREAD/MWRITE command constants, identical to the CPU's mem_cmd encoding;
  - the FSM state encoding IDLE/ACCESS/WAIT/ACK.
- One sub-module, mem_arb_rr: a combinational 2-way round-robin picker. Inputs are req[1:0] and last_grant; outputs are grant_valid and grant_id. The fixed-priority macro is applied inside it.
- The top level contains the FSM, the latch registers and the RAM drive.

## Test plan
- Reset then single write: m0 MWRITE addr=0x05 wdata=0xBEEF → ram_write=1 with ram_addr=0x05 and ram_din=0xBEEF in c1; m0_ack in c2.
- Read back: m0 MREAD addr=0x05 → m0_ack in c3 with rdata=0xBEEF; m1_ack stays 0.
- Simultaneous MREAD from m0 (0x05) and m1 (0x06, preloaded 0x1234) just after reset → m0 is served first, then m1. The next simultaneous pair serves m1 first. With FIXED_PRIO_EN, m0 is always served first.
- Non-RAM address: m1 MREAD addr=0x140 → no ram_write, no ack, state stays IDLE.
- Reset asserted in the ACCESS cycle of a write to 0x10 → ram_write=0, no ack, and RAM[0x10] is unchanged. After reset, rdata=0 and the first grant goes to m0.
- Command 11 on m0 → ignored (treated as MNONE).
